// File: rtl/countdown_rx_light.sv
// Countdown frame receiver: deserializes LSB-first digits, drives 7-seg and traffic lamps.
// Optional yellow blink on digit updates when COUNTDOWN_RX_BLINK_EN is defined.
module countdown_rx_light #(
  parameter int DATA_W      = 8,
  parameter int FRAME_SKIP  = 1,
  parameter int START_PHASE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_in,
  input  logic       frame_in,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic [6:0] seg,
  output logic       red,
  output logic       yellow,
  output logic       green,
  output logic       frame_err
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  localparam logic [1:0] SKIP_N = 2'(FRAME_SKIP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } rx_t;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } ph_t;

  localparam ph_t PH0 = ph_t'(2'(START_PHASE));

  rx_t              rx_q, rx_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CW-1:0]    n_q, n_d;
  logic [1:0]       skip_q, skip_d;
  logic             armed_q, armed_d;
  logic             pend_q, pend_d;
  logic             take, drop;
  logic             payload_ok, good, bad;

  ph_t              ph_q, ph_d;
  logic             adv;
  logic             yel_d;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Receiver next-state; data bits shift in from the top so bit 0 lands at sr[0]
  always_comb begin
    rx_d    = rx_q;
    sr_d    = sr_q;
    n_d     = n_q;
    skip_d  = skip_q;
    pend_d  = 1'b0;
    take    = 1'b0;
    drop    = 1'b0;
    armed_d = armed_q | ~frame_in;
    case (rx_q)
      IDLE: begin
        if (frame_in && armed_q) begin
          if (SKIP_N == 2'd0) begin
            take = 1'b1;
          end else begin
            skip_d = 2'd1;
            rx_d   = SKIP;
          end
        end
      end
      SKIP: begin
        if (!frame_in) begin
          drop = 1'b1;
        end else if (skip_q >= SKIP_N) begin
          take = 1'b1;
        end else begin
          skip_d = skip_q + 2'd1;
        end
      end
      SHIFT: begin
        if (!frame_in) begin
          drop = 1'b1;
        end else begin
          take = 1'b1;
        end
      end
      DONE: begin
        if (!frame_in) begin
          rx_d   = IDLE;
          sr_d   = '0;
          n_d    = '0;
          skip_d = '0;
        end
      end
      default: rx_d = IDLE;
    endcase
    if (take) begin
      sr_d = {ser_in, sr_q[DATA_W-1:1]};
      n_d  = n_q + 1'b1;
      if (n_q == LAST) begin
        rx_d   = DONE;
        pend_d = 1'b1;
      end else begin
        rx_d = SHIFT;
      end
    end
    if (drop) begin
      rx_d   = IDLE;
      sr_d   = '0;
      n_d    = '0;
      skip_d = '0;
    end
  end

  assign payload_ok = ((sr_q >> 4) == '0) && (sr_q[3:0] <= 4'd9);
  assign good = pend_q & payload_ok;
  assign bad  = pend_q & ~payload_ok;

  // A frame already in flight at reset must end before the receiver re-arms
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q    <= IDLE;
      sr_q    <= '0;
      n_q     <= '0;
      skip_q  <= '0;
      pend_q  <= 1'b0;
      armed_q <= ~frame_in;
    end else begin
      rx_q    <= rx_d;
      sr_q    <= sr_d;
      n_q     <= n_d;
      skip_q  <= skip_d;
      pend_q  <= pend_d;
      armed_q <= armed_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit       <= 4'd0;
      digit_valid <= 1'b0;
      frame_err   <= 1'b0;
      seg         <= 7'b0111111;
    end else begin
      digit_valid <= good;
      frame_err   <= drop | bad;
      if (good) begin
        digit <= sr_q[3:0];
        seg   <= seg_of(sr_q[3:0]);
      end
    end
  end

  assign adv = digit_valid && (digit == 4'd0);

  always_comb begin
    ph_d = ph_q;
    if (adv) begin
      case (ph_q)
        RED:     ph_d = GREEN;
        GREEN:   ph_d = YELLOW;
        default: ph_d = RED;
      endcase
    end
  end

`ifdef COUNTDOWN_RX_BLINK_EN
  logic blink_q, blink_d;

  always_comb begin
    blink_d = blink_q;
    if (adv) begin
      blink_d = (ph_d == YELLOW);
    end else if (digit_valid && ph_q == YELLOW) begin
      blink_d = ~blink_q;
    end
    yel_d = (ph_d == YELLOW) & blink_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_q <= 1'b1;
    end else begin
      blink_q <= blink_d;
    end
  end
`else
  always_comb begin
    yel_d = (ph_d == YELLOW);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q   <= PH0;
      red    <= (PH0 == RED);
      green  <= (PH0 == GREEN);
      yellow <= (PH0 == YELLOW);
    end else begin
      ph_q   <= ph_d;
      red    <= (ph_d == RED);
      green  <= (ph_d == GREEN);
      yellow <= yel_d;
    end
  end

endmodule

// File: tb/tb_countdown_rx_light.sv
// Bench for countdown_rx_light: frame-level reference model with random payloads.
module tb_countdown_rx_light;

  logic       clk = 1'b0;
  logic       rst;
  logic       ser_in;
  logic       frame_in;
  logic [3:0] digit;
  logic       digit_valid;
  logic [6:0] seg;
  logic       red;
  logic       yellow;
  logic       green;
  logic       frame_err;

  localparam logic [6:0] SEGT [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

  int checks = 0;
  int passes = 0;
  int onehot_bad = 0;
  int m_digit = 0;
  int m_phase = 0;

  countdown_rx_light dut (
    .clk(clk),
    .rst(rst),
    .ser_in(ser_in),
    .frame_in(frame_in),
    .digit(digit),
    .digit_valid(digit_valid),
    .seg(seg),
    .red(red),
    .yellow(yellow),
    .green(green),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst === 1'b0 && $countones({red, yellow, green}) != 1) onehot_bad++;
  end

  function automatic logic [2:0] lamps_of(input int ph);
    case (ph)
      0: return 3'b100;
      1: return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

  function automatic int frame_ok(input logic [7:0] p, input int nb);
    return (nb == 8 && p <= 8'd9) ? 1 : 0;
  endfunction

  task automatic model_frame(input logic [7:0] p, input int nb);
    if (frame_ok(p, nb) == 1) begin
      m_digit = int'(p);
      if (p == 8'd0) m_phase = (m_phase + 1) % 3;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] p, input int nb, input int extra,
                            output int dvn, output int errn);
    dvn = 0;
    errn = 0;
    frame_in = 1'b1;
    ser_in = 1'($urandom);
    tick();
    dvn += int'(digit_valid);
    errn += int'(frame_err);
    for (int i = 0; i < nb; i++) begin
      ser_in = p[i];
      tick();
      dvn += int'(digit_valid);
      errn += int'(frame_err);
    end
    for (int i = 0; i < extra; i++) begin
      ser_in = 1'($urandom);
      tick();
      dvn += int'(digit_valid);
      errn += int'(frame_err);
    end
    frame_in = 1'b0;
    ser_in = 1'($urandom);
    tick();
    dvn += int'(digit_valid);
    errn += int'(frame_err);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame_in = 1'b0;
    ser_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    m_digit = 0;
    m_phase = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (digit !== 4'd0) $display("FAIL reset_digit got %0d want 0", digit);
    else passes++;
    checks++;
    if (digit_valid !== 1'b0) $display("FAIL reset_dv got %b want 0", digit_valid);
    else passes++;
    checks++;
    if (frame_err !== 1'b0) $display("FAIL reset_err got %b want 0", frame_err);
    else passes++;
    checks++;
    if (seg !== SEGT[0]) $display("FAIL reset_seg got %b want %b", seg, SEGT[0]);
    else passes++;
    checks++;
    if ({red, yellow, green} !== lamps_of(m_phase))
      $display("FAIL reset_lamps got %b want %b", {red, yellow, green}, lamps_of(m_phase));
    else passes++;
    tick();
  endtask

  task automatic test_single_frame();
    logic [7:0] v;
    v = 8'h07;
    frame_in = 1'b1;
    ser_in = 1'($urandom);
    tick();
    for (int i = 0; i < 8; i++) begin
      ser_in = v[i];
      tick();
    end
    checks++;
    if (digit_valid !== 1'b0) $display("FAIL single_early_dv got %b want 0", digit_valid);
    else passes++;
    frame_in = 1'b0;
    tick();
    model_frame(v, 8);
    checks++;
    if (digit_valid !== 1'b1) $display("FAIL single_dv got %b want 1", digit_valid);
    else passes++;
    checks++;
    if (digit !== 4'(m_digit)) $display("FAIL single_digit got %0d want %0d", digit, m_digit);
    else passes++;
    checks++;
    if (seg !== SEGT[m_digit]) $display("FAIL single_seg got %b want %b", seg, SEGT[m_digit]);
    else passes++;
    tick();
    checks++;
    if (digit_valid !== 1'b0) $display("FAIL single_dv_width got %b want 0", digit_valid);
    else passes++;
    checks++;
    if ({red, yellow, green} !== lamps_of(m_phase))
      $display("FAIL single_lamps got %b want %b", {red, yellow, green}, lamps_of(m_phase));
    else passes++;
  endtask

  task automatic test_countdown();
    int dvn, errn, total;
    total = 0;
    for (int v = 9; v >= 0; v--) begin
      send_frame(8'(v), 8, 0, dvn, errn);
      model_frame(8'(v), 8);
      total += dvn;
      checks++;
      if (digit !== 4'(m_digit)) $display("FAIL countdown_digit got %0d want %0d", digit, m_digit);
      else passes++;
    end
    checks++;
    if (total !== 10) $display("FAIL countdown_pulses got %0d want 10", total);
    else passes++;
    checks++;
    if ({red, yellow, green} !== 3'b100)
      $display("FAIL countdown_lamps_before got %b want 100", {red, yellow, green});
    else passes++;
    tick();
    checks++;
    if ({red, yellow, green} !== lamps_of(m_phase))
      $display("FAIL countdown_lamps_after got %b want %b", {red, yellow, green}, lamps_of(m_phase));
    else passes++;
  endtask

  task automatic test_short_frame();
    int dvn, errn;
    send_frame(8'($urandom), 5, 0, dvn, errn);
    checks++;
    if (errn !== 1) $display("FAIL short_err got %0d want 1", errn);
    else passes++;
    checks++;
    if (dvn !== 0) $display("FAIL short_dv got %0d want 0", dvn);
    else passes++;
    checks++;
    if (digit !== 4'(m_digit)) $display("FAIL short_digit got %0d want %0d", digit, m_digit);
    else passes++;
    checks++;
    if (seg !== SEGT[m_digit]) $display("FAIL short_seg got %b want %b", seg, SEGT[m_digit]);
    else passes++;
    tick();
    checks++;
    if ({red, yellow, green} !== lamps_of(m_phase))
      $display("FAIL short_lamps got %b want %b", {red, yellow, green}, lamps_of(m_phase));
    else passes++;
    send_frame(8'h03, 8, 0, dvn, errn);
    model_frame(8'h03, 8);
    checks++;
    if (dvn !== 1 || digit !== 4'(m_digit))
      $display("FAIL short_next got dv=%0d digit=%0d want dv=1 digit=%0d", dvn, digit, m_digit);
    else passes++;
  endtask

  task automatic test_bad_payload();
    int dvn, errn;
    logic [7:0] bad [2];
    bad[0] = 8'h0C;
    bad[1] = 8'h13;
    for (int i = 0; i < 2; i++) begin
      send_frame(bad[i], 8, 0, dvn, errn);
      checks++;
      if (errn !== 1 || dvn !== 0)
        $display("FAIL bad_payload_%0h got err=%0d dv=%0d want err=1 dv=0", bad[i], errn, dvn);
      else passes++;
      checks++;
      if (digit !== 4'(m_digit)) $display("FAIL bad_payload_digit got %0d want %0d", digit, m_digit);
      else passes++;
    end
  endtask

  task automatic test_phase();
    int dvn, errn;
    do_reset();
    tick();
    for (int i = 0; i < 3; i++) begin
      send_frame(8'h00, 8, 0, dvn, errn);
      model_frame(8'h00, 8);
      tick();
      checks++;
      if ({red, yellow, green} !== lamps_of(m_phase))
        $display("FAIL phase_%0d got %b want %b", i, {red, yellow, green}, lamps_of(m_phase));
      else passes++;
    end
    checks++;
    if (onehot_bad !== 0) $display("FAIL phase_onehot got %0d want 0", onehot_bad);
    else passes++;
  endtask

  task automatic test_reset_mid_frame();
    int dvn, errn;
    logic [7:0] v;
    v = 8'h06;
    dvn = 0;
    errn = 0;
    frame_in = 1'b1;
    ser_in = 1'($urandom);
    tick();
    for (int i = 0; i < 3; i++) begin
      ser_in = v[i];
      tick();
    end
    rst = 1'b1;
    ser_in = v[3];
    tick();
    rst = 1'b0;
    m_digit = 0;
    m_phase = 0;
    for (int i = 0; i < 6; i++) begin
      ser_in = 1'($urandom);
      tick();
      dvn += int'(digit_valid);
      errn += int'(frame_err);
    end
    frame_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      dvn += int'(digit_valid);
      errn += int'(frame_err);
    end
    checks++;
    if (dvn !== 0 || errn !== 0)
      $display("FAIL abort_pulses got dv=%0d err=%0d want 0 0", dvn, errn);
    else passes++;
    checks++;
    if (digit !== 4'(m_digit)) $display("FAIL abort_digit got %0d want %0d", digit, m_digit);
    else passes++;
    send_frame(8'h05, 8, 0, dvn, errn);
    model_frame(8'h05, 8);
    checks++;
    if (dvn !== 1 || digit !== 4'(m_digit))
      $display("FAIL abort_next got dv=%0d digit=%0d want dv=1 digit=%0d", dvn, digit, m_digit);
    else passes++;
  endtask

  task automatic test_random();
    int dvn, errn, nb, extra, ok;
    logic [7:0] p;
    for (int k = 0; k < 24; k++) begin
      p = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 8;
      extra = (nb == 8) ? int'($urandom_range(0, 2)) : 0;
      ok = frame_ok(p, nb);
      send_frame(p, nb, extra, dvn, errn);
      model_frame(p, nb);
      checks++;
      if (dvn !== ok || errn !== 1 - ok)
        $display("FAIL rand_%0d p=%0h nb=%0d got dv=%0d err=%0d want dv=%0d err=%0d",
                 k, p, nb, dvn, errn, ok, 1 - ok);
      else passes++;
      checks++;
      if (digit !== 4'(m_digit) || seg !== SEGT[m_digit])
        $display("FAIL rand_out_%0d got %0d/%b want %0d/%b", k, digit, seg, m_digit, SEGT[m_digit]);
      else passes++;
    end
    tick();
    checks++;
    if ({red, yellow, green} !== lamps_of(m_phase))
      $display("FAIL rand_lamps got %b want %b", {red, yellow, green}, lamps_of(m_phase));
    else passes++;
    checks++;
    if (onehot_bad !== 0) $display("FAIL rand_onehot got %0d want 0", onehot_bad);
    else passes++;
  endtask

  initial begin
    rst = 1'b1;
    frame_in = 1'b0;
    ser_in = 1'b0;
    test_reset();
    test_single_frame();
    test_countdown();
    test_short_frame();
    test_bad_payload();
    test_phase();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
